// File: rtl/counter_button_ctrl.sv
// ============================================================================
//  Module      : counter_button_ctrl
//  Description : Push-button front-end for the 4-bit up/down counter.
//                Synchronises, debounces and auto-repeats three buttons.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module counter_button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16,
    parameter int VALUE_W         = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_load,
    input  logic [VALUE_W-1:0] load_value,
    output logic               enable,
    output logic               up_down,
    output logic               set,
    output logic [VALUE_W-1:0] set_value
);

    localparam int c_DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_TW   = $clog2(c_TMAX + 1);

    localparam logic [c_DW-1:0] c_DB_LAST = c_DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DW-1:0] c_DB_ONE  = c_DW'(1);
    localparam logic [c_TW-1:0] c_DELAY   = c_TW'(REPEAT_DELAY);
    localparam logic [c_TW-1:0] c_PERIOD  = c_TW'(REPEAT_PERIOD);
    localparam logic [c_TW-1:0] c_T_ONE   = c_TW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2,
        S_LOCK   = 2'd3
    } state_t;

    // Bit order everywhere: 0 = up, 1 = down, 2 = load
    logic [2:0] w_raw;
    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] w_deb;
    logic [2:0] r_deb_q;
    logic [2:0] w_rise;

    assign w_raw = {btn_load, btn_down, btn_up};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb_q <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_deb_q <= w_deb;
        end
    end

    generate
        for (genvar i = 0; i < 3; i++) begin : g_debounce
            logic [c_DW-1:0] r_cnt;
            logic            r_state;

            // Flip only after DEBOUNCE_CYCLES consecutive disagreeing samples
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt   <= '0;
                    r_state <= 1'b0;
                end else if (r_sync2[i] == r_state) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_cnt   <= '0;
                    r_state <= r_sync2[i];
                end else begin
                    r_cnt <= r_cnt + c_DB_ONE;
                end
            end

            assign w_deb[i] = r_state;
        end
    endgenerate

    assign w_rise = w_deb & ~r_deb_q;

    state_t          r_state;
    logic [c_TW-1:0] r_timer;
    logic            w_held;
    logic            w_other;

    // up_down always names the direction currently being held
    assign w_held  = up_down ? w_deb[0] : w_deb[1];
    assign w_other = up_down ? w_deb[1] : w_deb[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            enable    <= 1'b0;
            up_down   <= 1'b1;
            set       <= 1'b0;
            set_value <= '0;
        end else begin
            enable <= 1'b0;
            set    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_rise[2]) begin
                        set       <= 1'b1;
                        set_value <= load_value;
                    end else if (w_rise[0] && w_rise[1]) begin
                        r_state <= S_LOCK;
                    end else if (w_rise[0] && !w_deb[1]) begin
                        enable  <= 1'b1;
                        up_down <= 1'b1;
                        r_timer <= c_DELAY;
                        r_state <= S_HOLD;
                    end else if (w_rise[1] && !w_deb[0]) begin
                        enable  <= 1'b1;
                        up_down <= 1'b0;
                        r_timer <= c_DELAY;
                        r_state <= S_HOLD;
                    end else if (w_rise[0] || w_rise[1]) begin
                        r_state <= S_LOCK;
                    end
                end
                S_HOLD, S_REPEAT: begin
                    if (w_rise[2]) begin
                        set       <= 1'b1;
                        set_value <= load_value;
                        r_state   <= S_LOCK;
                    end else if (w_other) begin
                        r_state <= S_LOCK;
                    end else if (!w_held) begin
                        r_state <= S_IDLE;
                    end else if (r_timer <= c_T_ONE) begin
                        enable  <= 1'b1;
                        r_timer <= c_PERIOD;
                        r_state <= S_REPEAT;
                    end else begin
                        r_timer <= r_timer - c_T_ONE;
                    end
                end
                S_LOCK: begin
                    if (!w_deb[0] && !w_deb[1]) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_counter_button_ctrl.sv
// ============================================================================
//  Module      : tb_counter_button_ctrl
//  Description : Directed self-checking bench for counter_button_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_counter_button_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_up;
    logic       btn_down;
    logic       btn_load;
    logic [3:0] load_value;
    logic       enable;
    logic       up_down;
    logic       set;
    logic [3:0] set_value;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0;

    int en_cyc[$];
    int en_dir[$];
    int set_cyc[$];
    int set_val[$];

    int exp3[8] = '{7, 17, 20, 23, 26, 29, 32, 35};
    int exp6[5] = '{7, 17, 20, 23, 26};

    counter_button_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .VALUE_W        (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_load  (btn_load),
        .load_value(load_value),
        .enable    (enable),
        .up_down   (up_down),
        .set       (set),
        .set_value (set_value)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample outputs 1 time unit after the edge, log strobes
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check("enable_set_exclusive", int'(enable & set), 0);
        if (enable === 1'b1) begin
            en_cyc.push_back(cyc);
            en_dir.push_back(int'(up_down));
        end
        if (set === 1'b1) begin
            set_cyc.push_back(cyc);
            set_val.push_back(int'(set_value));
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_logs();
        en_cyc.delete();
        en_dir.delete();
        set_cyc.delete();
        set_val.delete();
    endtask

    task automatic expect_en(input string tag, input int idx, input int exp_cyc, input int exp_dir);
        check({tag, "_cycle"}, (idx < en_cyc.size()) ? en_cyc[idx] : -1, exp_cyc);
        check({tag, "_dir"},   (idx < en_dir.size()) ? en_dir[idx] : -1, exp_dir);
    endtask

    initial begin
        reset      = 1'b1;
        btn_up     = 1'b0;
        btn_down   = 1'b0;
        btn_load   = 1'b0;
        load_value = 4'h0;

        // 1: reset values, then quiet idle
        ticks(3);
        check("rst_enable",    int'(enable),    0);
        check("rst_set",       int'(set),       0);
        check("rst_set_value", int'(set_value), 0);
        check("rst_up_down",   int'(up_down),   1);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_enable",    int'(enable),    0);
            check("idle_set",       int'(set),       0);
            check("idle_set_value", int'(set_value), 0);
            check("idle_up_down",   int'(up_down),   1);
        end

        // 2: short up press, single pulse 7 cycles after the rise
        clear_logs();
        t0 = cyc;
        btn_up = 1'b1;
        ticks(8);
        btn_up = 1'b0;
        ticks(30);
        check("up_single_count", en_cyc.size(), 1);
        expect_en("up_single", 0, t0 + 7, 1);
        check("up_single_no_set", set_cyc.size(), 0);

        // 3: down held 30 cycles, delay 10 then period 3
        clear_logs();
        t0 = cyc;
        btn_down = 1'b1;
        ticks(30);
        btn_down = 1'b0;
        ticks(30);
        check("down_repeat_count", en_cyc.size(), 8);
        for (int i = 0; i < 8; i++) expect_en("down_repeat", i, t0 + exp3[i], 0);

        // 4: 3-cycle glitches never pass the debouncer
        clear_logs();
        for (int k = 0; k < 5; k++) begin
            btn_up = 1'b1;
            ticks(3);
            btn_up = 1'b0;
            ticks(3);
        end
        ticks(20);
        check("glitch_count", en_cyc.size(), 0);
        check("glitch_dir_held", int'(up_down), 0);

        // 5: load press gives one set with the sampled value
        clear_logs();
        t0 = cyc;
        load_value = 4'hA;
        btn_load = 1'b1;
        ticks(6);
        btn_load = 1'b0;
        ticks(20);
        check("load_set_count", set_cyc.size(), 1);
        check("load_set_cycle", (set_cyc.size() > 0) ? set_cyc[0] : -1, t0 + 7);
        check("load_set_value", (set_val.size() > 0) ? set_val[0] : -1, 10);
        check("load_no_enable", en_cyc.size(), 0);

        // 6a: up repeating, down pressed at +22 -> lock before the +29 pulse
        clear_logs();
        t0 = cyc;
        btn_up = 1'b1;
        ticks(22);
        btn_down = 1'b1;
        ticks(18);
        btn_down = 1'b0;
        ticks(20);
        check("lock_count", en_cyc.size(), 5);
        for (int i = 0; i < 5; i++) expect_en("lock", i, t0 + exp6[i], 1);

        // 6b: releasing both returns to idle; a fresh press gives one pulse
        clear_logs();
        btn_up = 1'b0;
        ticks(20);
        check("lock_release_quiet", en_cyc.size(), 0);
        t0 = cyc;
        btn_up = 1'b1;
        ticks(8);
        btn_up = 1'b0;
        ticks(20);
        check("fresh_count", en_cyc.size(), 1);
        expect_en("fresh", 0, t0 + 7, 1);

        // 6c: reset while holding down in HOLD
        clear_logs();
        t0 = cyc;
        btn_down = 1'b1;
        ticks(9);
        check("pre_reset_count", en_cyc.size(), 1);
        expect_en("pre_reset", 0, t0 + 7, 0);
        clear_logs();
        reset    = 1'b1;
        btn_down = 1'b0;
        #1;
        check("midrst_enable",    int'(enable),    0);
        check("midrst_set",       int'(set),       0);
        check("midrst_set_value", int'(set_value), 0);
        check("midrst_up_down",   int'(up_down),   1);
        ticks(3);
        reset = 1'b0;
        ticks(30);
        check("post_reset_enables", en_cyc.size(), 0);
        check("post_reset_sets",    set_cyc.size(), 0);
        check("post_reset_up_down", int'(up_down), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
